// File: rtl/spi_reg_peripheral.sv
`default_nettype none
// ==================================================================
// Module   : spi_reg_peripheral - oversampled SPI mode-0 write target
// Revision : 1.0 - initial release
// ==================================================================
module spi_reg_peripheral #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [6:0] MAX_ADDR    = 7'd4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       ncs,
    input  logic       copi,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       write_pulse
);

    localparam int NUM_REGS = 5;
    localparam int FLUSH_W  = $clog2(SYNC_STAGES + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHIFT   = 2'd1,
        ST_FULL    = 2'd2,
        ST_OVERRUN = 2'd3
    } state_t;

    state_t                 r_state, w_next_state;
    logic [SYNC_STAGES-1:0] r_sclk_sync, r_ncs_sync, r_copi_sync;
    logic                   r_sclk_d, r_ncs_d;
    logic [FLUSH_W-1:0]     r_flush_cnt;
    logic                   r_armed;
    logic [15:0]            r_shift;
    logic [4:0]             r_bit_cnt;
    logic [7:0]             r_regs [NUM_REGS];
    logic                   r_write_pulse;

    logic w_sclk_s, w_ncs_s, w_copi_s;
    logic w_sclk_rise, w_ncs_rise, w_ncs_fall;
    logic w_clear, w_shift_en, w_commit_try, w_commit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync <= '0;
            r_ncs_sync  <= '1;
            r_copi_sync <= '0;
            r_sclk_d    <= 1'b0;
            r_ncs_d     <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0], ncs};
            r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], copi};
            r_sclk_d    <= w_sclk_s;
            r_ncs_d     <= w_ncs_s;
        end
    end

    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_ncs_s     = r_ncs_sync[SYNC_STAGES-1];
    assign w_copi_s    = r_copi_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
    assign w_ncs_rise  = w_ncs_s & ~r_ncs_d;
    assign w_ncs_fall  = ~w_ncs_s & r_ncs_d;

    // The ncs chain resets high, so a pin already low at release would look
    // like a fresh frame start; only arm once the flushed chain has seen ncs high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flush_cnt <= '0;
            r_armed     <= 1'b0;
        end else if (r_flush_cnt != FLUSH_W'(SYNC_STAGES)) begin
            r_flush_cnt <= r_flush_cnt + 1'b1;
        end else if (w_ncs_s) begin
            r_armed     <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    // ncs edges are tested before sclk so a coincident sclk rise is ignored.
    always_comb begin
        w_next_state = r_state;
        w_clear      = 1'b0;
        w_shift_en   = 1'b0;
        w_commit_try = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_ncs_fall && r_armed) begin
                    w_next_state = ST_SHIFT;
                    w_clear      = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (w_ncs_rise) begin
                    w_next_state = ST_IDLE;
                end else if (w_sclk_rise) begin
                    w_shift_en = 1'b1;
                    if (r_bit_cnt == 5'd15) w_next_state = ST_FULL;
                end
            end
            ST_FULL: begin
                if (w_ncs_rise) begin
                    w_commit_try = 1'b1;
                    w_next_state = ST_IDLE;
                end else if (w_sclk_rise) begin
                    w_next_state = ST_OVERRUN;
                end
            end
            ST_OVERRUN: begin
                if (w_ncs_rise) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    assign w_commit = w_commit_try && r_shift[15] && (r_shift[14:8] <= MAX_ADDR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (w_clear) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (w_shift_en) begin
            r_shift   <= {r_shift[14:0], w_copi_s};
            r_bit_cnt <= r_bit_cnt + 5'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
            r_write_pulse <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_commit && (r_shift[14:8] == 7'(i))) r_regs[i] <= r_shift[7:0];
            end
            r_write_pulse <= w_commit;
        end
    end

    assign en_reg_out_7_0  = r_regs[0];
    assign en_reg_out_15_8 = r_regs[1];
    assign en_reg_pwm_7_0  = r_regs[2];
    assign en_reg_pwm_15_8 = r_regs[3];
    assign pwm_duty_cycle  = r_regs[4];
    assign write_pulse     = r_write_pulse;

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_peripheral.sv
`default_nettype none
// ==================================================================
// Module   : tb_spi_reg_peripheral - scoreboard bench for spi_reg_peripheral
// Revision : 1.0 - initial release
// ==================================================================
module tb_spi_reg_peripheral;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk = 1'b0;
    logic       ncs = 1'b1;
    logic       copi = 1'b0;
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
    logic       write_pulse;

    spi_reg_peripheral #(.SYNC_STAGES(2), .MAX_ADDR(7'd4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .sclk            (sclk),
        .ncs             (ncs),
        .copi            (copi),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .write_pulse     (write_pulse)
    );

    always #50 clk = ~clk;

    typedef struct {
        logic [6:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t        exp_q [$];
    wr_t        r_pop;
    logic [7:0] model [5];
    int         checks = 0;
    int         errors = 0;
    int         pulse_cnt = 0;
    int         pulse_base;
    logic       r_pulse_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] dut_reg(input int a);
        case (a)
            0:       return en_reg_out_7_0;
            1:       return en_reg_out_15_8;
            2:       return en_reg_pwm_7_0;
            3:       return en_reg_pwm_15_8;
            default: return pwm_duty_cycle;
        endcase
    endfunction

    task automatic check_regs(input string tag);
        for (int i = 0; i < 5; i++)
            check($sformatf("%s_reg%0d", tag, i), 32'(dut_reg(i)), 32'(model[i]));
    endtask

    // Scoreboard side: each write_pulse retires one expected write.
    always @(negedge clk) begin
        if (rst_n && write_pulse) begin
            pulse_cnt++;
            check("pulse_single_cycle", 32'(r_pulse_prev), 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                r_pop = exp_q.pop_front();
                model[r_pop.addr] = r_pop.data;
                check_regs("on_pulse");
            end
        end
        r_pulse_prev = rst_n && write_pulse;
    end

    task automatic spi_bits(input logic [31:0] word, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            copi = word[i];
            repeat (5) @(negedge clk);
            sclk = 1'b1;
            repeat (5) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [31:0] word, input int n);
        wr_t w;
        @(negedge clk);
        ncs = 1'b0;
        if (n == 16 && word[15] && word[14:8] <= 7'd4) begin
            w.addr = word[14:8];
            w.data = word[7:0];
            exp_q.push_back(w);
        end
        repeat (5) @(negedge clk);
        spi_bits(word, n);
        repeat (5) @(negedge clk);
        ncs = 1'b1;
        repeat (6) @(negedge clk);
        check("commit_within_latency", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 5; i++) model[i] = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_pulse", 32'(write_pulse), 32'd0);
        check_regs("reset");
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        pulse_base = pulse_cnt;
        send_frame(32'h80F0, 16);
        check_regs("wr_out_lo");
        check("wr_out_lo_pulses", 32'(pulse_cnt - pulse_base), 32'd1);

        pulse_base = pulse_cnt;
        send_frame(32'h8480, 16);
        send_frame(32'h84FF, 16);
        check("duty_val", 32'(pwm_duty_cycle), 32'hFF);
        check("duty_pulses", 32'(pulse_cnt - pulse_base), 32'd2);

        pulse_base = pulse_cnt;
        send_frame(32'h8555, 16);
        send_frame(32'h00AA, 16);
        check_regs("bad_addr_read");
        check("bad_addr_read_pulses", 32'(pulse_cnt - pulse_base), 32'd0);

        pulse_base = pulse_cnt;
        send_frame(32'h81AB >> 4, 12);
        send_frame({15'd0, 16'h81AB, 1'b1}, 17);
        check("short_over_reg1", 32'(en_reg_out_15_8), 32'h00);
        check("short_over_pulses", 32'(pulse_cnt - pulse_base), 32'd0);
        send_frame(32'h81AB, 16);
        check("good_reg1", 32'(en_reg_out_15_8), 32'hAB);

        send_frame(32'h8203, 16);
        check("pwm_lo_set", 32'(en_reg_pwm_7_0), 32'h03);
        @(negedge clk);
        ncs = 1'b0;
        repeat (5) @(negedge clk);
        spi_bits(32'h82, 8);
        rst_n = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 5; i++) model[i] = 8'h00;
        repeat (2) @(negedge clk);
        check("midframe_rst_pulse", 32'(write_pulse), 32'd0);
        check_regs("midframe_rst");
        rst_n = 1'b1;
        pulse_base = pulse_cnt;
        spi_bits(32'h03, 8);
        repeat (5) @(negedge clk);
        ncs = 1'b1;
        repeat (6) @(negedge clk);
        check("after_rst_tail_pulses", 32'(pulse_cnt - pulse_base), 32'd0);
        check_regs("after_rst_tail");
        send_frame(32'h8203, 16);
        check("pwm_lo_restored", 32'(en_reg_pwm_7_0), 32'h03);

        pulse_base = pulse_cnt;
        send_frame(32'h8011, 16);
        send_frame(32'h8122, 16);
        send_frame(32'h8233, 16);
        send_frame(32'h8344, 16);
        send_frame(32'h8455, 16);
        check("b2b_reg0", 32'(en_reg_out_7_0), 32'h11);
        check("b2b_reg1", 32'(en_reg_out_15_8), 32'h22);
        check("b2b_reg2", 32'(en_reg_pwm_7_0), 32'h33);
        check("b2b_reg3", 32'(en_reg_pwm_15_8), 32'h44);
        check("b2b_reg4", 32'(pwm_duty_cycle), 32'h55);
        check("b2b_pulses", 32'(pulse_cnt - pulse_base), 32'd5);

        repeat (20) @(negedge clk);
        check("final_regs_hold", 32'(en_reg_out_7_0), 32'h11);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
